// File: rtl/melody_sequencer.sv
// Beat-level melody sequencer: steps a 64-beat song ROM at a fixed tempo and
// drives a square-wave tone generator with the half-period of each note.
module melody_sequencer #(
    parameter int unsigned BEAT_CYC = 25_000_000,
    parameter int unsigned GAP_CYC  = 2_500_000
) (
    input  logic        sys_CLK,
    input  logic        rst_n,
    input  logic        play,
    input  logic        loop_en,
    output logic [17:0] half_period,
    output logic [4:0]  note_code,
    output logic [5:0]  beat_pos,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = $clog2(BEAT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEAT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_CYC - GAP_CYC);

    // Liangzhu theme; 1-7 low octave, 8-14 middle, 15-21 high, 0 rest.
    localparam logic [4:0] SONG [0:63] = '{
        5'd3,  5'd3,  5'd3,  5'd3,  5'd5,  5'd5,  5'd5,  5'd6,
        5'd8,  5'd8,  5'd9,  5'd6,  5'd8,  5'd5,  5'd5,  5'd5,
        5'd12, 5'd12, 5'd12, 5'd15, 5'd13, 5'd12, 5'd10, 5'd12,
        5'd9,  5'd9,  5'd9,  5'd9,  5'd10, 5'd7,  5'd6,  5'd6,
        5'd5,  5'd5,  5'd5,  5'd6,  5'd8,  5'd8,  5'd9,  5'd9,
        5'd3,  5'd3,  5'd8,  5'd6,  5'd5,  5'd6,  5'd8,  5'd5,
        5'd12, 5'd15, 5'd13, 5'd12, 5'd10, 5'd12, 5'd9,  5'd5,
        5'd5,  5'd5,  5'd5,  5'd5,  5'd5,  5'd5,  5'd5,  5'd5
    };

    typedef enum logic {IDLE, PLAY} state_t;

    function automatic logic [17:0] tone_of(input logic [4:0] code);
        logic [4:0]  idx;
        logic [1:0]  oct;
        logic [17:0] base;
        idx = 5'd0;
        oct = 2'd0;
        if (code >= 5'd1 && code <= 5'd7) begin
            idx = code;
        end else if (code >= 5'd8 && code <= 5'd14) begin
            idx = code - 5'd7;
            oct = 2'd1;
        end else if (code >= 5'd15 && code <= 5'd21) begin
            idx = code - 5'd14;
            oct = 2'd2;
        end
        case (idx)
            5'd1:    base = 18'd191113;
            5'd2:    base = 18'd170265;
            5'd3:    base = 18'd151686;
            5'd4:    base = 18'd143171;
            5'd5:    base = 18'd127551;
            5'd6:    base = 18'd113636;
            5'd7:    base = 18'd101239;
            default: base = 18'd0;
        endcase
        return base >> oct;
    endfunction

    state_t           state, nxt_state;
    logic             play_d;
    logic             start;
    logic [CNT_W-1:0] beat_cnt, nxt_cnt;
    logic [5:0]       nxt_pos;
    logic             nxt_done;
    logic [4:0]       cur_code, following_code;
    logic             differs, in_gap;

    always_comb begin
        start     = play & ~play_d;
        nxt_state = state;
        nxt_pos   = beat_pos;
        nxt_cnt   = beat_cnt;
        nxt_done  = 1'b0;
        case (state)
            IDLE: begin
                nxt_pos = 6'd0;
                nxt_cnt = '0;
                if (start) nxt_state = PLAY;
            end
            PLAY: begin
                if (!play) begin
                    nxt_state = IDLE;
                    nxt_pos   = 6'd0;
                    nxt_cnt   = '0;
                end else if (beat_cnt == LAST_CNT) begin
                    nxt_cnt = '0;
                    if (beat_pos == 6'd63 && !loop_en) begin
                        nxt_state = IDLE;
                        nxt_pos   = 6'd0;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_pos = beat_pos + 6'd1;
                    end
                end else begin
                    nxt_cnt = beat_cnt + CNT_W'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // The 6-bit wrap makes beat 63 look ahead to beat 0; without looping the
    // song ends, so the last beat always releases.
    always_comb begin
        cur_code       = SONG[nxt_pos];
        following_code = SONG[nxt_pos + 6'd1];
        differs        = (following_code != cur_code) || (nxt_pos == 6'd63 && !loop_en);
        in_gap         = (GAP_CYC != 0) && (nxt_cnt >= GAP_START) && differs;
    end

    always_ff @(posedge sys_CLK) begin
        if (!rst_n) begin
            state       <= IDLE;
            play_d      <= 1'b0;
            beat_cnt    <= '0;
            beat_pos    <= 6'd0;
            note_code   <= 5'd0;
            half_period <= 18'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state    <= nxt_state;
            play_d   <= play;
            beat_cnt <= nxt_cnt;
            beat_pos <= nxt_pos;
            done     <= nxt_done;
            busy     <= (nxt_state == PLAY);
            if (nxt_state == PLAY) begin
                note_code   <= cur_code;
                half_period <= in_gap ? 18'd0 : tone_of(cur_code);
            end else begin
                note_code   <= 5'd0;
                half_period <= 18'd0;
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed table-driven bench for melody_sequencer with BEAT_CYC=10, GAP_CYC=2.
module tb_melody_sequencer;

    logic        sys_CLK;
    logic        rst_n;
    logic        play;
    logic        loop_en;
    logic [17:0] half_period;
    logic [4:0]  note_code;
    logic [5:0]  beat_pos;
    logic        busy;
    logic        done;

    melody_sequencer #(.BEAT_CYC(10), .GAP_CYC(2)) dut (
        .sys_CLK     (sys_CLK),
        .rst_n       (rst_n),
        .play        (play),
        .loop_en     (loop_en),
        .half_period (half_period),
        .note_code   (note_code),
        .beat_pos    (beat_pos),
        .busy        (busy),
        .done        (done)
    );

    initial sys_CLK = 1'b0;
    always #5 sys_CLK = ~sys_CLK;

    typedef struct {
        logic        rst_n;
        logic        play;
        logic        loop_en;
        int          adv;
        logic        full;
        logic        busy;
        logic [5:0]  pos;
        logic [4:0]  note;
        logic [17:0] half;
        logic        done;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic step();
        @(posedge sys_CLK);
        #1;
    endtask

    task automatic check(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row=%0d actual=%0d expected=%0d", nm, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic p, input logic l, input int a, input logic f,
                       input logic b, input logic [5:0] bp, input logic [4:0] nc,
                       input logic [17:0] hp, input logic d);
        vec_t v;
        v.rst_n = r; v.play = p; v.loop_en = l; v.adv = a; v.full = f;
        v.busy = b; v.pos = bp; v.note = nc; v.half = hp; v.done = d;
        tbl.push_back(v);
    endtask

    initial begin
        int n_busy;
        int n_gap;
        logic seen_done;

        rst_n = 1'b0; play = 1'b0; loop_en = 1'b0;
        step();
        check("reset_busy", -1, 32'(busy), 0);
        check("reset_done", -1, 32'(done), 0);
        check("reset_pos",  -1, 32'(beat_pos), 0);
        check("reset_note", -1, 32'(note_code), 0);
        check("reset_half", -1, 32'(half_period), 0);

        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", i, {12'd0, busy, done, beat_pos, note_code, 7'd0} | 32'(half_period), 0);
        end

        // Non-looping run: start, legato beats 0-3, gaps, natural end.
        add(1,1,0,  1, 1, 1, 0, 3, 151686, 0);
        add(1,1,0,  9, 1, 1, 0, 3, 151686, 0);
        add(1,1,0,  1, 1, 1, 1, 3, 151686, 0);
        add(1,1,0, 27, 1, 1, 3, 3, 151686, 0);
        add(1,1,0,  1, 1, 1, 3, 3, 0,      0);
        add(1,1,0,  1, 1, 1, 3, 3, 0,      0);
        add(1,1,0,  1, 1, 1, 4, 5, 127551, 0);
        add(1,1,0,  8, 1, 1, 4, 5, 127551, 0);
        add(1,1,0, 20, 1, 1, 6, 5, 0,      0);
        add(1,1,0,  2, 1, 1, 7, 6, 113636, 0);
        add(1,1,0,558, 1, 1,62, 5, 127551, 0);
        add(1,1,0,  9, 1, 1,63, 5, 127551, 0);
        add(1,1,0,  1, 1, 1,63, 5, 0,      0);
        add(1,1,0,  1, 1, 1,63, 5, 0,      0);
        add(1,1,0,  1, 1, 0, 0, 0, 0,      1);
        add(1,1,0,  1, 1, 0, 0, 0, 0,      0);
        add(1,1,0, 20, 1, 0, 0, 0, 0,      0);
        // Looping run: gap before the wrap, no done.
        add(1,0,1,  1, 1, 0, 0, 0, 0,      0);
        add(1,1,1,  1, 1, 1, 0, 3, 151686, 0);
        add(1,1,1,637, 1, 1,63, 5, 127551, 0);
        add(1,1,1,  1, 1, 1,63, 5, 0,      0);
        add(1,1,1,  1, 1, 1,63, 5, 0,      0);
        add(1,1,1,  1, 1, 1, 0, 3, 151686, 0);
        add(1,1,1, 10, 1, 1, 1, 3, 151686, 0);
        // Stop at beat 10 of the second lap.
        add(1,1,1, 90, 0, 1,10, 0, 0,      0);
        add(1,0,1,  1, 1, 0, 0, 0, 0,      0);
        add(1,0,1,  3, 1, 0, 0, 0, 0,      0);
        // Reset mid-beat, then restart.
        add(1,1,1,  1, 1, 1, 0, 3, 151686, 0);
        add(1,1,1, 25, 1, 1, 2, 3, 151686, 0);
        add(0,1,1,  1, 1, 0, 0, 0, 0,      0);
        add(1,0,1,  1, 1, 0, 0, 0, 0,      0);
        add(1,1,1,  1, 1, 1, 0, 3, 151686, 0);
        add(1,1,1,  4, 1, 1, 0, 3, 151686, 0);

        foreach (tbl[r]) begin
            rst_n = tbl[r].rst_n; play = tbl[r].play; loop_en = tbl[r].loop_en;
            repeat (tbl[r].adv) step();
            check("busy", r, 32'(busy), 32'(tbl[r].busy));
            check("pos",  r, 32'(beat_pos), 32'(tbl[r].pos));
            check("done", r, 32'(done), 32'(tbl[r].done));
            if (tbl[r].full) begin
                check("note", r, 32'(note_code), 32'(tbl[r].note));
                check("half", r, 32'(half_period), 32'(tbl[r].half));
            end
        end

        // Fresh non-looping run: count busy cycles and silent cycles in beats 0-3.
        play = 1'b0; loop_en = 1'b0;
        step();
        play = 1'b1;
        n_busy = 0; n_gap = 0; seen_done = 1'b0;
        for (int i = 0; i < 1000 && !seen_done; i++) begin
            step();
            if (done) seen_done = 1'b1;
            if (busy) n_busy++;
            if (busy && n_busy <= 40 && half_period == 18'd0) n_gap++;
        end
        check("run_done_seen",  -2, 32'(seen_done), 1);
        check("run_busy_cycles", -2, n_busy, 640);
        check("run_gap_beats0to3", -2, n_gap, 2);
        step();
        check("run_done_width", -2, 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
